// File: rtl/bus_pkg.sv
// Shared widths, FSM encoding and timeout fill value for the two-master bus arbiter.
package bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/bus_rr_pick.sv
// Two-way round-robin choice: a sole requester wins, a tie goes to the master not granted last.
// Purely combinational; the caller decides whether any request is present.
module bus_rr_pick (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    always_comb begin
        grant = 1'b0;
        case (req)
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master to one-slave bus arbiter: IDLE -> ISSUE -> (WAIT) -> RESP, one transaction at a time.
// Optional read-wait timeout enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_rd_en,
    input  logic              m0_wr_en,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic [DATA_W-1:0] m0_rd_data,
    output logic              m0_done,
    output logic              m0_err,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_rd_en,
    input  logic              m1_wr_en,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              m1_done,
    output logic              m1_err,
    output logic [ADDR_W-1:0] s_addr,
    output logic              s_rd_en,
    output logic              s_wr_en,
    output logic [DATA_W-1:0] s_wr_data,
    input  logic [DATA_W-1:0] s_rd_data,
    input  logic              s_rd_valid
);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              op_wr_q, op_wr_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic [DATA_W-1:0] s_wr_data_q, s_wr_data_d;
    logic              s_rd_en_q, s_rd_en_d;
    logic              s_wr_en_q, s_wr_en_d;
    logic              m0_done_q, m0_done_d, m1_done_q, m1_done_d;
    logic [DATA_W-1:0] m0_rd_data_q, m0_rd_data_d, m1_rd_data_q, m1_rd_data_d;

    logic [1:0] req;
    logic       pick;
    logic       fin_done;
    logic       fin_err;
    logic       fin_load;
    logic [DATA_W-1:0] fin_data;

    assign req = {m1_rd_en | m1_wr_en, m0_rd_en | m0_wr_en};

    bus_rr_pick u_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (pick)
    );

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       m0_err_q, m0_err_d, m1_err_q, m1_err_d;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_wr_d      = op_wr_q;
        s_addr_d     = s_addr_q;
        s_wr_data_d  = s_wr_data_q;
        s_rd_en_d    = 1'b0;
        s_wr_en_d    = 1'b0;
        fin_done     = 1'b0;
        fin_err      = 1'b0;
        fin_load     = 1'b0;
        fin_data     = s_rd_data;
`ifdef BUS_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    // A write wins over a read when a master raises both.
                    last_grant_d = pick;
                    op_wr_d      = pick ? m1_wr_en : m0_wr_en;
                    s_addr_d     = pick ? m1_addr : m0_addr;
                    s_wr_data_d  = pick ? m1_wr_data : m0_wr_data;
                    s_wr_en_d    = op_wr_d;
                    s_rd_en_d    = ~op_wr_d;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (op_wr_q) begin
                    fin_done = 1'b1;
                    state_d  = ST_RESP;
                end else begin
`ifdef BUS_ARB_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (s_rd_valid) begin
                    fin_done = 1'b1;
                    fin_load = 1'b1;
                    state_d  = ST_RESP;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    fin_err  = 1'b1;
                    fin_load = 1'b1;
                    fin_data = TIMEOUT_DATA;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Completion side effects all target the master recorded in last_grant_q.
    assign m0_done_d    = fin_done & ~last_grant_q;
    assign m1_done_d    = fin_done &  last_grant_q;
    assign m0_rd_data_d = (fin_load && !last_grant_q) ? fin_data : m0_rd_data_q;
    assign m1_rd_data_d = (fin_load &&  last_grant_q) ? fin_data : m1_rd_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            op_wr_q      <= 1'b0;
            s_addr_q     <= '0;
            s_wr_data_q  <= '0;
            s_rd_en_q    <= 1'b0;
            s_wr_en_q    <= 1'b0;
            m0_done_q    <= 1'b0;
            m1_done_q    <= 1'b0;
            m0_rd_data_q <= '0;
            m1_rd_data_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_wr_q      <= op_wr_d;
            s_addr_q     <= s_addr_d;
            s_wr_data_q  <= s_wr_data_d;
            s_rd_en_q    <= s_rd_en_d;
            s_wr_en_q    <= s_wr_en_d;
            m0_done_q    <= m0_done_d;
            m1_done_q    <= m1_done_d;
            m0_rd_data_q <= m0_rd_data_d;
            m1_rd_data_q <= m1_rd_data_d;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    assign m0_err_d = fin_err & ~last_grant_q;
    assign m1_err_d = fin_err &  last_grant_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= 8'd0;
            m0_err_q <= 1'b0;
            m1_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            m0_err_q <= m0_err_d;
            m1_err_q <= m1_err_d;
        end
    end

    assign m0_err = m0_err_q;
    assign m1_err = m1_err_q;
`else
    assign m0_err = fin_err;
    assign m1_err = fin_err;
`endif

    assign s_addr     = s_addr_q;
    assign s_wr_data  = s_wr_data_q;
    assign s_rd_en    = s_rd_en_q;
    assign s_wr_en    = s_wr_en_q;
    assign m0_done    = m0_done_q;
    assign m1_done    = m1_done_q;
    assign m0_rd_data = m0_rd_data_q;
    assign m1_rd_data = m1_rd_data_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a 1-cycle-latency slave model and a completion scoreboard.
// Define BUS_ARB_TIMEOUT_EN to exercise the read timeout with TIMEOUT_CYCLES=4.
module tb_bus_arbiter;
    import bus_pkg::*;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int TB_TO = 4;
`else
    localparam int TB_TO = 16;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] m0_addr, m1_addr, s_addr;
    logic        m0_rd_en, m0_wr_en, m1_rd_en, m1_wr_en;
    logic [31:0] m0_wr_data, m1_wr_data, m0_rd_data, m1_rd_data;
    logic        m0_done, m0_err, m1_done, m1_err;
    logic        s_rd_en, s_wr_en, s_rd_valid;
    logic [31:0] s_wr_data, s_rd_data;

    logic        slv_vld = 1'b0, tb_vld = 1'b0;
    logic [31:0] slv_dat = '0, tb_dat = '0;
    bit          slv_mute = 1'b0;

    typedef struct {
        bit          mst;
        bit          err;
        bit          chk;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT_CYCLES(TB_TO)) dut (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_rd_en(m0_rd_en), .m0_wr_en(m0_wr_en), .m0_wr_data(m0_wr_data),
        .m0_rd_data(m0_rd_data), .m0_done(m0_done), .m0_err(m0_err),
        .m1_addr(m1_addr), .m1_rd_en(m1_rd_en), .m1_wr_en(m1_wr_en), .m1_wr_data(m1_wr_data),
        .m1_rd_data(m1_rd_data), .m1_done(m1_done), .m1_err(m1_err),
        .s_addr(s_addr), .s_rd_en(s_rd_en), .s_wr_en(s_wr_en), .s_wr_data(s_wr_data),
        .s_rd_data(s_rd_data), .s_rd_valid(s_rd_valid)
    );

    function automatic logic [31:0] resp_fn(input logic [15:0] a);
        return (a == 16'h4000) ? 32'h0000_0001 : {~a, a};
    endfunction

    // Slave answers one cycle after seeing its read strobe.
    always @(posedge clk) begin
        slv_vld <= 1'b0;
        if (s_rd_en === 1'b1 && !slv_mute) begin
            slv_vld <= 1'b1;
            slv_dat <= resp_fn(s_addr);
        end
    end

    assign s_rd_valid = slv_vld | tb_vld;
    assign s_rd_data  = slv_vld ? slv_dat : tb_dat;

    // Scoreboard: every done/err pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        bit [1:0]    fin;
        bit [1:0]    errs;
        logic [31:0] rdv [2];
        exp_t        e;
        fin     = {m1_done === 1'b1 || m1_err === 1'b1, m0_done === 1'b1 || m0_err === 1'b1};
        errs    = {m1_err === 1'b1, m0_err === 1'b1};
        rdv[0]  = m0_rd_data;
        rdv[1]  = m1_rd_data;
        if (fin != 2'b00) begin
            checks++;
            if (fin == 2'b11) begin
                failures++;
                $display("FAIL both_masters_complete: actual=%b required=single", fin);
            end
            for (int k = 0; k < 2; k++) begin
                if (fin[k]) begin
                    checks++;
                    if (sbq.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_completion: master=%0d with no pending request", k);
                    end else begin
                        e = sbq.pop_front();
                        checks++;
                        if (e.mst !== k[0]) begin
                            failures++;
                            $display("FAIL sb_master: actual=%0d required=%0d", k, e.mst);
                        end
                        checks++;
                        if (errs[k] !== e.err) begin
                            failures++;
                            $display("FAIL sb_err_flag: actual=%0b required=%0b", errs[k], e.err);
                        end
                        if (e.chk) begin
                            checks++;
                            if (rdv[k] !== e.data) begin
                                failures++;
                                $display("FAIL sb_rd_data: master=%0d actual=%h required=%h", k, rdv[k], e.data);
                            end
                        end
                    end
                end
            end
        end
    end

    // Drives one request at a negedge in IDLE and watches the buses until completion.
    task automatic run_req(input bit mst, input bit rd, input bit wr, input logic [15:0] a,
                           input logic [31:0] d, output int lat, output int wr_p, output int rd_p,
                           output logic [15:0] seen_a, output logic [31:0] seen_d, output int other_p,
                           output bit got);
        lat = 0; wr_p = 0; rd_p = 0; seen_a = '0; seen_d = '0; other_p = 0; got = 1'b0;
        @(negedge clk);
        if (mst) begin m1_addr = a; m1_wr_data = d; m1_rd_en = rd; m1_wr_en = wr; end
        else     begin m0_addr = a; m0_wr_data = d; m0_rd_en = rd; m0_wr_en = wr; end
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (s_wr_en === 1'b1) begin wr_p++; seen_a = s_addr; seen_d = s_wr_data; end
            if (s_rd_en === 1'b1) begin rd_p++; seen_a = s_addr; end
            if ((mst ? m0_done : m1_done) === 1'b1) other_p++;
            if ((mst ? (m1_done | m1_err) : (m0_done | m0_err)) === 1'b1) begin
                lat = i; got = 1'b1; break;
            end
        end
        if (mst) begin m1_rd_en = 1'b0; m1_wr_en = 1'b0; end
        else     begin m0_rd_en = 1'b0; m0_wr_en = 1'b0; end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL req_completion: actual=none_in_64_cycles required=done_or_err");
        end
    endtask

    task automatic test_reset();
        logic [137:0] outs;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        outs = {s_rd_en, s_wr_en, s_addr, s_wr_data, m0_done, m0_err, m0_rd_data,
                m1_done, m1_err, m1_rd_data};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL reset_outputs: actual=%h required=0", outs);
        end
        rst = 1'b0;
    endtask

    task automatic test_read();
        int lat, wp, rp, op; logic [15:0] sa; logic [31:0] sd; bit got;
        sbq.push_back('{mst: 1'b1, err: 1'b0, chk: 1'b1, data: 32'h0000_0001});
        run_req(1'b1, 1'b1, 1'b0, 16'h4000, 32'h0, lat, wp, rp, sa, sd, op, got);
        checks++; if (lat != 3) begin failures++; $display("FAIL read_latency: actual=%0d required=3", lat); end
        checks++; if (rp != 1 || wp != 0) begin failures++; $display("FAIL read_strobes: actual rd=%0d wr=%0d required rd=1 wr=0", rp, wp); end
        checks++; if (sa !== 16'h4000) begin failures++; $display("FAIL read_addr: actual=%h required=4000", sa); end
        checks++; if (m1_rd_data !== 32'h1) begin failures++; $display("FAIL read_data: actual=%h required=00000001", m1_rd_data); end
        checks++; if (op != 0) begin failures++; $display("FAIL read_other_done: actual=%0d required=0", op); end
    endtask

    task automatic test_write();
        int lat, wp, rp, op; logic [15:0] sa; logic [31:0] sd; bit got;
        sbq.push_back('{mst: 1'b0, err: 1'b0, chk: 1'b0, data: 32'h0});
        run_req(1'b0, 1'b0, 1'b1, 16'h0010, 32'h1234_5678, lat, wp, rp, sa, sd, op, got);
        checks++; if (lat != 2) begin failures++; $display("FAIL write_latency: actual=%0d required=2", lat); end
        checks++; if (wp != 1 || rp != 0) begin failures++; $display("FAIL write_strobes: actual wr=%0d rd=%0d required wr=1 rd=0", wp, rp); end
        checks++; if (sa !== 16'h0010 || sd !== 32'h1234_5678) begin failures++; $display("FAIL write_bus: actual=%h/%h required=0010/12345678", sa, sd); end
        repeat (2) @(negedge clk);
        checks++; if (s_addr !== 16'h0010 || s_wr_data !== 32'h1234_5678 || s_wr_en !== 1'b0) begin
            failures++; $display("FAIL write_hold: actual=%h/%h/%b required=0010/12345678/0", s_addr, s_wr_data, s_wr_en);
        end
        checks++; if (m1_rd_data !== 32'h1) begin failures++; $display("FAIL rd_data_hold: actual=%h required=00000001", m1_rd_data); end
        // Read and write raised together must behave as a write.
        sbq.push_back('{mst: 1'b1, err: 1'b0, chk: 1'b0, data: 32'h0});
        run_req(1'b1, 1'b1, 1'b1, 16'h0020, 32'hA5A5_5A5A, lat, wp, rp, sa, sd, op, got);
        checks++; if (wp != 1 || rp != 0 || lat != 2) begin
            failures++; $display("FAIL rdwr_as_write: actual wr=%0d rd=%0d lat=%0d required wr=1 rd=0 lat=2", wp, rp, lat);
        end
        checks++; if (sd !== 32'hA5A5_5A5A) begin failures++; $display("FAIL rdwr_data: actual=%h required=a5a55a5a", sd); end
    endtask

    task automatic test_back_to_back();
        int n = 0; int t[4]; bit ord[4];
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        m0_addr = 16'h0100; m1_addr = 16'h0200; m0_rd_en = 1'b1; m1_rd_en = 1'b1;
        for (int k = 0; k < 4; k++)
            sbq.push_back('{mst: k[0], err: 1'b0, chk: 1'b1, data: resp_fn(k[0] ? 16'h0200 : 16'h0100)});
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (m0_done === 1'b1 || m1_done === 1'b1) begin
                ord[n] = (m1_done === 1'b1); t[n] = i; n++;
                if (n == 4) break;
            end
        end
        m0_rd_en = 1'b0; m1_rd_en = 1'b0;
        checks++;
        if (n != 4) begin
            failures++; $display("FAIL b2b_count: actual=%0d required=4", n);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (ord[k] !== k[0]) begin failures++; $display("FAIL b2b_order: slot=%0d actual=m%0d required=m%0d", k, ord[k], k[0]); end
            end
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (t[k] - t[k-1] != 4) begin failures++; $display("FAIL b2b_spacing: slot=%0d actual=%0d required=4", k, t[k] - t[k-1]); end
            end
        end
        repeat (2) @(negedge clk);
    endtask

`ifdef BUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int lat, wp, rp, op; logic [15:0] sa; logic [31:0] sd; bit got;
        slv_mute = 1'b1;
        sbq.push_back('{mst: 1'b0, err: 1'b1, chk: 1'b1, data: TIMEOUT_DATA});
        run_req(1'b0, 1'b1, 1'b0, 16'h0300, 32'h0, lat, wp, rp, sa, sd, op, got);
        checks++; if (lat != TB_TO + 2) begin failures++; $display("FAIL timeout_latency: actual=%0d required=%0d", lat, TB_TO + 2); end
        checks++; if (m0_err !== 1'b1 || m0_done !== 1'b0) begin failures++; $display("FAIL timeout_flags: actual err=%b done=%b required err=1 done=0", m0_err, m0_done); end
        checks++; if (m0_rd_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL timeout_data: actual=%h required=deadbeef", m0_rd_data); end
        @(negedge clk);
        checks++; if (m0_err !== 1'b0) begin failures++; $display("FAIL timeout_pulse_width: actual=%b required=0", m0_err); end
        slv_mute = 1'b0;
        sbq.push_back('{mst: 1'b0, err: 1'b0, chk: 1'b0, data: 32'h0});
        run_req(1'b0, 1'b0, 1'b1, 16'h0310, 32'h0000_0310, lat, wp, rp, sa, sd, op, got);
        checks++; if (lat != 2) begin failures++; $display("FAIL after_timeout_idle: actual=%0d required=2", lat); end
    endtask
`else
    task automatic test_wait_forever();
        bit early = 1'b0;
        slv_mute = 1'b1;
        @(negedge clk);
        m0_addr = 16'h0600; m0_rd_en = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (m0_done === 1'b1 || m0_err === 1'b1) early = 1'b1;
        end
        checks++; if (early) begin failures++; $display("FAIL wait_no_timeout: actual=completed required=still_waiting"); end
        sbq.push_back('{mst: 1'b0, err: 1'b0, chk: 1'b1, data: 32'hCAFE_0001});
        tb_dat = 32'hCAFE_0001; tb_vld = 1'b1;
        @(negedge clk);
        tb_vld = 1'b0;
        checks++; if (m0_done !== 1'b1 || m0_err !== 1'b0) begin failures++; $display("FAIL late_valid_done: actual done=%b err=%b required done=1 err=0", m0_done, m0_err); end
        m0_rd_en = 1'b0;
        slv_mute = 1'b0;
        @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid_wait();
        logic [137:0] outs; bit pulse = 1'b0;
        checks++; if (sbq.size() != 0) begin failures++; $display("FAIL pending_before_reset: actual=%0d required=0", sbq.size()); end
        slv_mute = 1'b1;
        @(negedge clk);
        m0_addr = 16'h0500; m0_rd_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1; m0_rd_en = 1'b0;
        @(negedge clk);
        outs = {s_rd_en, s_wr_en, s_addr, s_wr_data, m0_done, m0_err, m0_rd_data,
                m1_done, m1_err, m1_rd_data};
        checks++; if (outs !== '0) begin failures++; $display("FAIL midwait_reset_outputs: actual=%h required=0", outs); end
        rst = 1'b0; tb_dat = 32'h1357_9BDF; tb_vld = 1'b1;
        @(negedge clk);
        tb_vld = 1'b0;
        repeat (6) begin
            if (m0_done === 1'b1 || m0_err === 1'b1 || m1_done === 1'b1 || m1_err === 1'b1) pulse = 1'b1;
            @(negedge clk);
        end
        checks++; if (pulse) begin failures++; $display("FAIL midwait_pulse: actual=pulse required=none"); end
        slv_mute = 1'b0;
    endtask

    task automatic test_stray_valid();
        bit moved = 1'b0;
        @(negedge clk);
        tb_dat = 32'hFFFF_FFFF; tb_vld = 1'b1;
        @(negedge clk);
        tb_vld = 1'b0;
        repeat (3) begin
            if (m0_rd_data !== 32'h0 || m1_rd_data !== 32'h0 || m0_done !== 1'b0 || m1_done !== 1'b0 ||
                s_rd_en !== 1'b0 || s_wr_en !== 1'b0) moved = 1'b1;
            @(negedge clk);
        end
        checks++; if (moved) begin failures++; $display("FAIL stray_valid: actual=outputs_changed required=unchanged"); end
        checks++; if (m0_rd_data !== 32'h0) begin failures++; $display("FAIL stray_rd_data: actual=%h required=0", m0_rd_data); end
    endtask

    initial begin
        rst = 1'b1;
        m0_addr = '0; m0_rd_en = 1'b0; m0_wr_en = 1'b0; m0_wr_data = '0;
        m1_addr = '0; m1_rd_en = 1'b0; m1_wr_en = 1'b0; m1_wr_data = '0;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
`ifdef BUS_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_wait_forever();
`endif
        test_reset_mid_wait();
        test_stray_valid();
        checks++;
        if (sbq.size() != 0) begin
            failures++; $display("FAIL sb_leftover: actual=%0d required=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=still_running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the read-wait limit in cycles (range 2..255).
REQ-002 SHALL have ports:
 clk  in  1  system clock; all logic on rising edge
 rst  in  1  reset, synchronous, active-high
 m0_addr  in  16  master 0 byte address
 m0_rd_en  in  1  master 0 read request (level)
 m0_wr_en  in  1  master 0 write request (level)
 m0_wr_data  in  32  master 0 write data
 m0_rd_data  out  32  master 0 read data
 m0_done  out  1  master 0 completion pulse
 m0_err  out  1  master 0 timeout pulse
 m1_*  same set as m0_*, for master 1
 s_addr  out  16  shared bus address
 s_rd_en  out  1  shared bus read strobe
 s_wr_en  out  1  shared bus write strobe
 s_wr_data  out  32  shared bus write data
 s_rd_data  in  32  shared bus read data
 s_rd_valid  in  1  shared bus read-data valid
REQ-003 SHALL decide clocking and reset as: one clock (clk); reset rst is synchronous and active-high.

Function
REQ-004 SHALL have a request protocol where a master raises rd_en or wr_en and holds it, along with addr and wr_data, stable until its done (or err) pulse; it drops the request in the cycle after that pulse.
REQ-005 SHALL treat rd_en and wr_en both high on one master as a write only.
REQ-006 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP.
REQ-007 SHALL, in IDLE with any request, select one master, latch its addr, wr_data and op, and move to ISSUE.
REQ-008 SHALL arbitrate round-robin: a sole requester wins; if both request, the master not granted last wins; last_grant updates on every selection.
REQ-009 SHALL, in ISSUE, drive s_rd_en or s_wr_en high for exactly one cycle with the latched s_addr and s_wr_data; a write then goes to RESP and a read goes to WAIT.
REQ-010 SHALL, in WAIT, capture s_rd_data into the granted master's rd_data when s_rd_valid is high, then move to RESP.
REQ-011 SHALL ignore s_rd_valid outside WAIT.
REQ-012 SHALL, in RESP, hold the granted master's done high for exactly one cycle, then return to IDLE.
REQ-013 SHALL hold m*_rd_data until that master's next read completes.
REQ-014 SHALL register all outputs; s_* are zero outside ISSUE, except s_addr and s_wr_data, which hold their last value.
REQ-015 SHALL meet these latencies with a slave of 1-cycle read latency, counted from the request being seen in IDLE at cycle N: write done at N+2; read done at N+3.
REQ-016 SHALL give a request arriving while the other master is being served no effect until IDLE; with both masters requesting continuously, grants alternate.

Reset
REQ-017 SHALL, while rst is high at a clock edge: state=IDLE; last_grant=1 (so m0 wins the first tie); s_rd_en, s_wr_en, s_addr and s_wr_data are 0; m*_done, m*_err and m*_rd_data are 0; the timeout counter is 0.
REQ-018 SHALL abandon any in-flight transaction on reset mid-operation, with no done or err pulse generated for it.

Configuration
REQ-019 SHALL, with BUS_ARB_TIMEOUT_EN defined: count WAIT cycles, and if s_rd_valid is absent after TIMEOUT_CYCLES cycles, load rd_data=32'hDEAD_BEEF, pulse err (not done) for one cycle in place of done, and return to IDLE.
REQ-020 SHALL, without BUS_ARB_TIMEOUT_EN: have no counter, tie m*_err to 0, and leave WAIT only on s_rd_valid (it may wait indefinitely).

Structure
REQ-021 SHALL place ADDR_W=16, DATA_W=32, the FSM state enum and the TIMEOUT_DATA=32'hDEAD_BEEF constant in shared package bus_pkg.
REQ-022 SHALL implement the two-way round-robin choice in combinational sub-module bus_rr_pick (inputs req[1:0] and last_grant; output grant).

Verification
REQ-023 SHALL cover these directed scenarios:
 - m0 writes 0x1234_5678 to addr 0x0010 -> s_wr_en for one cycle with s_addr=0x0010 and that data; m0_done 2 cycles after the request.
 - m1 reads addr 0x4000 with slave returning 0x0000_0001 one cycle later -> m1_rd_data=0x1, m1_done 3 cycles after the request, m0_done stays 0.
 - m0 and m1 both read continuously from reset -> grant order m0, m1, m0, m1; no cycle with both done pulses high.
 - (BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4) read with slave never asserting s_rd_valid -> m0_err one cycle, m0_rd_data=0xDEAD_BEEF, m0_done 0, FSM back in IDLE.
 - rst asserted during WAIT, then s_rd_valid asserted -> no done or err pulse; all outputs 0 one cycle after the reset edge.
 - Stray s_rd_valid while IDLE -> no output change.
